// File: rtl/delayw_checker.sv
// Receive-side monitor for a fixed-latency sample delay: keeps its own input
// history and compares each DUT output against the input DELAY enabled cycles earlier.
module delayw_checker #(
  parameter int DW    = 8,
  parameter int DELAY = 1,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_ce,
  input  logic [DW-1:0]    i_stim,
  input  logic [DW-1:0]    i_resp,
  output logic             o_locked,
  output logic             o_mismatch,
  output logic [DW-1:0]    o_expected,
  output logic             o_error,
  output logic [CNT_W-1:0] o_sample_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int PW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int FW = $clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_ERROR} state_t;

  // Sized to a power of two so the pointer indexes it without width games;
  // only entries 0..DELAY-1 are ever used.
  logic [DW-1:0]    r_hist [2**PW];
  logic [PW-1:0]    r_wptr;
  logic [FW-1:0]    r_fill;
  state_t           r_state;
  logic             r_locked;
  logic             r_mismatch;
  logic [DW-1:0]    r_expected;
  logic             r_error;
  logic [CNT_W-1:0] r_sample_count;
  logic [CNT_W-1:0] r_err_count;

  logic             w_write;
  logic [DW-1:0]    w_oldest;
  logic [PW-1:0]    w_ptr_next;

  assign w_write    = i_ce & ~i_clear;
  assign w_oldest   = r_hist[r_wptr];
  assign w_ptr_next = (r_wptr == PW'(DELAY - 1)) ? '0 : r_wptr + 1'b1;

  // History is not reset: the fill count alone guards against stale data.
  always_ff @(posedge i_clk) begin
    if (w_write) r_hist[r_wptr] <= i_stim;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_wptr         <= '0;
      r_fill         <= '0;
      r_locked       <= 1'b0;
      r_mismatch     <= 1'b0;
      r_expected     <= '0;
      r_error        <= 1'b0;
      r_sample_count <= '0;
      r_err_count    <= '0;
    end else if (i_clear) begin
      r_state        <= S_IDLE;
      r_wptr         <= '0;
      r_fill         <= '0;
      r_locked       <= 1'b0;
      r_mismatch     <= 1'b0;
      r_expected     <= '0;
      r_error        <= 1'b0;
      r_sample_count <= '0;
      r_err_count    <= '0;
    end else begin
      r_mismatch <= 1'b0;
      if (i_ce) begin
        r_wptr <= w_ptr_next;
        case (r_state)
          S_IDLE: begin
            r_fill <= FW'(1);
            if (DELAY == 1) begin
              r_state  <= S_CHECK;
              r_locked <= 1'b1;
            end else begin
              r_state <= S_FILL;
            end
          end
          S_FILL: begin
            r_fill <= r_fill + 1'b1;
            if (r_fill == FW'(DELAY - 1)) begin
              r_state  <= S_CHECK;
              r_locked <= 1'b1;
            end
          end
          default: begin
            r_expected <= w_oldest;
            if (r_sample_count != CNT_MAX) r_sample_count <= r_sample_count + 1'b1;
            if (i_resp != w_oldest) begin
              r_mismatch <= 1'b1;
              r_error    <= 1'b1;
              r_state    <= S_ERROR;
              if (r_err_count != CNT_MAX) r_err_count <= r_err_count + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign o_locked       = r_locked;
  assign o_mismatch     = r_mismatch;
  assign o_expected     = r_expected;
  assign o_error        = r_error;
  assign o_sample_count = r_sample_count;
  assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_delayw_checker.sv
// Bench for delayw_checker: four instances (DELAY 1/4/2/1, last with 4-bit counters)
// share one stimulus stream and are compared against a queue-based reference model.
module tb_delayw_checker;

  localparam int NI = 4;
  localparam int DLY  [NI] = '{1, 4, 2, 1};
  localparam int CMAX [NI] = '{65535, 65535, 65535, 15};

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_clear = 1'b0;
  logic       i_ce = 1'b0;
  logic [7:0] i_stim = '0;
  logic [7:0] resp [NI];
  logic       locked [NI];
  logic       mm [NI];
  logic       err [NI];
  logic [7:0] expd [NI];
  logic [15:0] sc [NI];
  logic [15:0] ec [NI];
  logic [3:0] sc3, ec3;

  always #5 clk = ~clk;

  delayw_checker #(.DW(8), .DELAY(1), .CNT_W(16)) u_d1 (
    .i_clk(clk), .i_reset(i_reset), .i_clear(i_clear), .i_ce(i_ce), .i_stim(i_stim),
    .i_resp(resp[0]), .o_locked(locked[0]), .o_mismatch(mm[0]), .o_expected(expd[0]),
    .o_error(err[0]), .o_sample_count(sc[0]), .o_err_count(ec[0]));
  delayw_checker #(.DW(8), .DELAY(4), .CNT_W(16)) u_d4 (
    .i_clk(clk), .i_reset(i_reset), .i_clear(i_clear), .i_ce(i_ce), .i_stim(i_stim),
    .i_resp(resp[1]), .o_locked(locked[1]), .o_mismatch(mm[1]), .o_expected(expd[1]),
    .o_error(err[1]), .o_sample_count(sc[1]), .o_err_count(ec[1]));
  delayw_checker #(.DW(8), .DELAY(2), .CNT_W(16)) u_d2 (
    .i_clk(clk), .i_reset(i_reset), .i_clear(i_clear), .i_ce(i_ce), .i_stim(i_stim),
    .i_resp(resp[2]), .o_locked(locked[2]), .o_mismatch(mm[2]), .o_expected(expd[2]),
    .o_error(err[2]), .o_sample_count(sc[2]), .o_err_count(ec[2]));
  delayw_checker #(.DW(8), .DELAY(1), .CNT_W(4)) u_c4 (
    .i_clk(clk), .i_reset(i_reset), .i_clear(i_clear), .i_ce(i_ce), .i_stim(i_stim),
    .i_resp(resp[3]), .o_locked(locked[3]), .o_mismatch(mm[3]), .o_expected(expd[3]),
    .o_error(err[3]), .o_sample_count(sc3), .o_err_count(ec3));
  assign sc[3] = {12'd0, sc3};
  assign ec[3] = {12'd0, ec3};

  // Reference model: stimulus samples waiting to be compared, held in a queue.
  int m_hist [NI][$];
  int m_fill [NI];
  int m_exp  [NI];
  int m_sc   [NI];
  int m_ec   [NI];
  bit m_locked [NI];
  bit m_mm   [NI];
  bit m_err  [NI];

  int  pass_cnt = 0;
  int  total_cnt = 0;
  bit  ov_en = 1'b0;
  logic [7:0] ov_val = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s i%0d locked", ph, k), int'(locked[k]), int'(m_locked[k]));
      chk($sformatf("%s i%0d mismatch", ph, k), int'(mm[k]), int'(m_mm[k]));
      chk($sformatf("%s i%0d expected", ph, k), int'(expd[k]), m_exp[k]);
      chk($sformatf("%s i%0d error", ph, k), int'(err[k]), int'(m_err[k]));
      chk($sformatf("%s i%0d sample_count", ph, k), int'(sc[k]), m_sc[k]);
      chk($sformatf("%s i%0d err_count", ph, k), int'(ec[k]), m_ec[k]);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      m_hist[k].delete();
      m_fill[k] = 0; m_exp[k] = 0; m_sc[k] = 0; m_ec[k] = 0;
      m_locked[k] = 1'b0; m_mm[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
  task automatic step(input string ph, input bit ce, input bit clr, input logic [7:0] s,
                      input bit corrupt);
    int good;
    int e;
    i_ce = ce; i_clear = clr; i_stim = s;
    for (int k = 0; k < NI; k++) begin
      good = (m_fill[k] == DLY[k]) ? m_hist[k][0] : int'($urandom_range(0, 255));
      resp[k] = 8'(good);
      if (corrupt) resp[k] = resp[k] ^ 8'($urandom_range(1, 255));
      if (k == 0 && ov_en) resp[k] = ov_val;
    end
    $display("step %s ce=%0d clr=%0d stim=%02h resp=%02h/%02h/%02h/%02h", ph, ce, clr, s,
             resp[0], resp[1], resp[2], resp[3]);
    @(posedge clk);
    if (clr) begin
      model_clear();
    end else begin
      for (int k = 0; k < NI; k++) begin
        m_mm[k] = 1'b0;
        if (ce) begin
          if (m_fill[k] == DLY[k]) begin
            e = m_hist[k].pop_front();
            m_exp[k] = e;
            if (m_sc[k] < CMAX[k]) m_sc[k]++;
            if (int'(resp[k]) != e) begin
              m_mm[k] = 1'b1;
              m_err[k] = 1'b1;
              if (m_ec[k] < CMAX[k]) m_ec[k]++;
            end
          end else begin
            m_fill[k]++;
          end
          m_hist[k].push_back(int'(s));
          m_locked[k] = (m_fill[k] == DLY[k]);
        end
      end
    end
    #1;
    check_all(ph);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) resp[k] = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    i_reset = 1'b0;

    // Test 1: clean 0x11..0xAA stream
    for (int i = 1; i <= 10; i++) step("t1", 1'b1, 1'b0, 8'(8'h11 * i), 1'b0);
    chk("t1 d1 sample_count", int'(sc[0]), 9);
    chk("t3 d4 sample_count", int'(sc[1]), 6);
    step("clr", 1'b0, 1'b1, 8'h00, 1'b0);

    // Test 2: response expected to be 0x33 replaced by 0xA5
    for (int i = 1; i <= 10; i++) begin
      ov_en = (i == 4);
      ov_val = 8'hA5;
      step("t2", 1'b1, 1'b0, 8'(8'h11 * i), 1'b0);
      if (i == 4) begin
        chk("t2 mismatch pulse", int'(mm[0]), 1);
        chk("t2 expected", int'(expd[0]), 8'h33);
      end
    end
    ov_en = 1'b0;
    chk("t2 err_count", int'(ec[0]), 1);
    chk("t2 error sticky", int'(err[0]), 1);
    step("clr", 1'b0, 1'b1, 8'h00, 1'b0);

    // Test 3: DELAY=4 lock timing with 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step("t3", 1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 3) chk("t3 not locked", int'(locked[1]), 0);
      if (i == 4) chk("t3 locked", int'(locked[1]), 1);
      if (i == 5) chk("t3 first expected", int'(expd[1]), 1);
    end
    chk("t3 sample_count", int'(sc[1]), 4);

    // Random traffic with occasional corruption and clears
    for (int i = 0; i < 150; i++)
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
           8'($urandom), ($urandom_range(0, 9) == 0));

    // Test 4: ce every other cycle, stim changing on ce-low cycles
    for (int i = 0; i < 40; i++) step("t4", (i % 2 == 0), 1'b0, 8'($urandom), 1'b0);

    // Test 5: counter saturation on the 4-bit instance
    step("clr", 1'b0, 1'b1, 8'h00, 1'b0);
    step("t5", 1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step("t5", 1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("t5 err_count sat", int'(ec[3]), 15);
    chk("t5 sample_count sat", int'(sc[3]), 15);

    // Test 6: asynchronous reset mid-CHECK, then refill
    #1 i_reset = 1'b1;
    #1;
    model_clear();
    check_all("async_rst");
    @(posedge clk);
    #1 i_reset = 1'b0;
    for (int i = 0; i < 6; i++) step("t6", 1'b1, 1'b0, 8'($urandom), 1'b0);
    step("t6 clr+ce", 1'b1, 1'b1, 8'hFF, 1'b0);
    chk("t6 clear sample_count", int'(sc[1]), 0);
    for (int i = 0; i < 8; i++) step("t6", 1'b1, 1'b0, 8'($urandom), ($urandom_range(0, 3) == 0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
